// File: rtl/fpu_addsub_sequencer_if.sv
// Issue/collect bus between the add/sub sequencer and its environment.
// FPU_SEQ_STATUS_EN adds the out_flags result classification signal.
interface fpu_addsub_sequencer_if #(
    parameter int WIDTH    = 32,
    parameter int TAG_BITS = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                in_op;
    logic [TAG_BITS-1:0] in_tag;
    logic [WIDTH-1:0]    pipe_a;
    logic [WIDTH-1:0]    pipe_b;
    logic                pipe_op;
    logic [WIDTH-1:0]    pipe_r;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_r;
    logic [TAG_BITS-1:0] out_tag;
    logic                busy;
`ifdef FPU_SEQ_STATUS_EN
    logic [2:0]          out_flags;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, pipe_r, out_ready,
        output in_ready, pipe_a, pipe_b, pipe_op, out_valid, out_r, out_tag,
`ifdef FPU_SEQ_STATUS_EN
        output out_flags,
`endif
        output busy
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, pipe_r, out_ready,
        input  in_ready, pipe_a, pipe_b, pipe_op, out_valid, out_r, out_tag,
`ifdef FPU_SEQ_STATUS_EN
        input  out_flags,
`endif
        input  busy
    );
endinterface

// File: rtl/fpu_addsub_sequencer.sv
// Issue/collect wrapper around the fixed-latency FP add/sub pipeline with a credit-protected result FIFO.
// Define FPU_SEQ_STATUS_EN to store and report {nan, inf, zero} flags for each result.
module fpu_addsub_sequencer #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int LATENCY   = 5,
    parameter int DEPTH     = 8,
    parameter int TAG_BITS  = 4
) (
    input logic                    clk,
    input logic                    rst,
    fpu_addsub_sequencer_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    // One extra stage covers the pipe_* register in front of the datapath.
    localparam int STAGES = LATENCY + 1;
`ifdef FPU_SEQ_STATUS_EN
    localparam int ENT_W  = WIDTH + TAG_BITS + 3;
`else
    localparam int ENT_W  = WIDTH + TAG_BITS;
`endif

    if (WIDTH != 1 + EXP_BITS + MANT_BITS) begin : g_bad_format
        $error("WIDTH must equal 1 + EXP_BITS + MANT_BITS");
    end
    if (LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_sizes
        $error("LATENCY must be >= 1 and DEPTH a power of two >= 2");
    end

    logic [WIDTH-1:0]    pipe_a_q;
    logic [WIDTH-1:0]    pipe_b_q;
    logic                pipe_op_q;
    logic [STAGES-1:0]   dl_vld;
    logic [TAG_BITS-1:0] dl_tag [STAGES];
    logic [ENT_W-1:0]    mem [DEPTH];
    logic [ENT_W-1:0]    wr_entry;
    logic [ENT_W-1:0]    head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    credits;
    logic                accept;
    logic                pop;
    logic                wr_en;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_ready && bus.out_valid;
    assign wr_en  = dl_vld[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_a_q  <= '0;
            pipe_b_q  <= '0;
            pipe_op_q <= 1'b0;
            dl_vld    <= '0;
            for (int k = 0; k < STAGES; k++) dl_tag[k] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            credits   <= CNT_W'(DEPTH);
        end else begin
            if (accept) begin
                pipe_a_q  <= bus.in_a;
                pipe_b_q  <= bus.in_b;
                pipe_op_q <= bus.in_op;
            end
            dl_vld    <= {dl_vld[STAGES-2:0], accept};
            dl_tag[0] <= bus.in_tag;
            for (int k = 1; k < STAGES; k++) dl_tag[k] <= dl_tag[k-1];
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A credit is held from accept until the result leaves the FIFO, so writes never overflow.
            case ({accept, pop})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   credits <= credits + CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr] <= wr_entry;
    end

    assign head = mem[rd_ptr];

`ifdef FPU_SEQ_STATUS_EN
    logic [EXP_BITS-1:0]  r_exp;
    logic [MANT_BITS-1:0] r_frac;
    logic [2:0]           r_flags;

    assign r_exp    = bus.pipe_r[MANT_BITS +: EXP_BITS];
    assign r_frac   = bus.pipe_r[MANT_BITS-1:0];
    assign r_flags  = {(&r_exp) && (|r_frac), (&r_exp) && !(|r_frac), !(|r_exp) && !(|r_frac)};
    assign wr_entry = {r_flags, dl_tag[STAGES-1], bus.pipe_r};
    assign bus.out_flags = bus.out_valid ? head[WIDTH+TAG_BITS +: 3] : 3'b000;
`else
    assign wr_entry = {dl_tag[STAGES-1], bus.pipe_r};
`endif

    assign bus.pipe_a    = pipe_a_q;
    assign bus.pipe_b    = pipe_b_q;
    assign bus.pipe_op   = pipe_op_q;
    assign bus.out_r     = head[WIDTH-1:0];
    assign bus.out_tag   = head[WIDTH +: TAG_BITS];
    assign bus.out_valid = count != '0;
    assign bus.in_ready  = (credits != '0) && !rst;
    assign bus.busy      = credits != CNT_W'(DEPTH);
endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Directed bench for fpu_addsub_sequencer: a fixture FP pipeline feeds pipe_r, and a queue model
// of accepted operations predicts in_ready/out_valid/busy and the head result every cycle.
module tb_fpu_addsub_sequencer;
    localparam int L     = 5;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_addsub_sequencer_if #(.WIDTH(32), .TAG_BITS(4)) bus ();

    fpu_addsub_sequencer #(
        .WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .LATENCY(L), .DEPTH(DEPTH), .TAG_BITS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [63:0] s2d(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:23] == 8'h00) return {s[31], 63'b0};
        if (s[30:23] == 8'hFF) return {s[31], 11'h7FF, s[22:0], 29'b0};
        e = 11'(s[30:23]) + 11'd896;
        return {s[31], e, s[22:0], 29'b0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        int ne;
        if (d[62:52] == 11'h7FF) return (d[51:0] != 0) ? {d[63], 8'hFF, 23'h400000} : {d[63], 8'hFF, 23'h0};
        if (d[62:52] == 11'h000) return {d[63], 31'b0};
        ne = int'(d[62:52]) - 896;
        if (ne >= 255) return {d[63], 8'hFF, 23'h0};
        if (ne <= 0) return {d[63], 31'b0};
        return {d[63], ne[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic op);
        real x, y, r;
        x = $bitstoreal(s2d(a));
        y = $bitstoreal(s2d(b));
        r = op ? (x - y) : (x + y);
        return d2s($realtobits(r));
    endfunction

    function automatic logic [31:0] i2f(input int i);
        return d2s($realtobits(real'(i)));
    endfunction

    function automatic logic [2:0] classify(input logic [31:0] r);
        return {r[30:23] == 8'hFF && r[22:0] != 0, r[30:23] == 8'hFF && r[22:0] == 0,
                r[30:23] == 8'h00 && r[22:0] == 0};
    endfunction

    // Fixture datapath: L register stages after pipe_*.
    logic [31:0] pstage [L];
    initial begin
        for (int k = 0; k < L; k++) pstage[k] = '0;
        forever begin
            @(posedge clk);
            pstage[0] <= fp_op(bus.pipe_a, bus.pipe_b, bus.pipe_op);
            for (int k = 1; k < L; k++) pstage[k] <= pstage[k-1];
        end
    end
    assign bus.pipe_r = pstage[L-1];

    // Model: every accepted op is outstanding until popped; it becomes visible L+1 edges after accept.
    typedef struct {
        logic [31:0] r;
        logic [3:0]  tag;
        int          rdy;
    } exp_t;
    exp_t q[$];
    int   cyc = 0;
    int   pops = 0;
    int   first_pop = -1;
    int   last_pop = -1;

    initial begin
        logic acc, pp;
        forever begin
            @(posedge clk);
            acc = bus.in_valid && !rst && (q.size() < DEPTH);
            pp  = bus.out_ready && (q.size() > 0) && (q[0].rdy <= cyc);
            cyc++;
            if (rst) begin
                q.delete();
            end else begin
                if (pp) begin
                    void'(q.pop_front());
                    pops++;
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
                if (acc) q.push_back('{fp_op(bus.in_a, bus.in_b, bus.in_op), bus.in_tag, cyc + L + 1});
            end
        end
    end

    initial begin
        logic ev;
        forever begin
            @(negedge clk);
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("in_ready", bus.in_ready, !rst && (q.size() < DEPTH));
            chk("out_valid", bus.out_valid, ev);
            chk("busy", bus.busy, q.size() != 0);
            if (ev) begin
                chk("out_r", bus.out_r, q[0].r);
                chk("out_tag", bus.out_tag, q[0].tag);
`ifdef FPU_SEQ_STATUS_EN
                chk("out_flags", bus.out_flags, classify(q[0].r));
`endif
            end
            chk("no_overflow", dut.wr_en && dut.count == DEPTH && !(bus.out_ready && bus.out_valid), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        bus.out_ready = 1'b1;
        for (int k = 0; k < budget && q.size() != 0; k++) tick();
        bus.out_ready = 1'b0;
        chk("drain_empty", q.size(), 0);
    endtask

    // Issue one op with out_ready low; returns the number of edges from accept to out_valid.
    task automatic one_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [3:0] tag, output int lat);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_tag = tag;
        tick();
        bus.in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic pop_one();
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int acc;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 1'b0; bus.in_tag = '0;
        bus.out_ready = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pipe_a", bus.pipe_a, 0);
        chk("rst_credits", dut.credits, DEPTH);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Single op: 1.0 + 2.0 with tag 3.
        tick();
        one_op(32'h3F800000, 32'h40000000, 1'b0, 4'd3, lat);
        chk("single_latency", lat, L + 1);
        chk("single_pipe_a", bus.pipe_a, 32'h3F800000);
        chk("single_out_r", bus.out_r, 32'h40400000);
        chk("single_out_tag", bus.out_tag, 3);
        pop_one();
        @(negedge clk);
        chk("single_busy_after_pop", bus.busy, 0);

        // Back-to-back 20 ops with the consumer always ready.
        tick();
        pops = 0; first_pop = -1; last_pop = -1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1; bus.in_a = i2f(i + 1); bus.in_b = i2f(2 * i);
            bus.in_op = i[0]; bus.in_tag = 4'(i);
            @(negedge clk);
            chk("b2b_in_ready", bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        drain(40);
        chk("b2b_pops", pops, 20);
        chk("b2b_one_per_cycle", last_pop - first_pop, 19);

        // Backpressure: only DEPTH accepts with the consumer stalled.
        acc = 0;
        for (int k = 0; k < 14; k++) begin
            bus.in_valid = 1'b1; bus.in_a = i2f(100 + k); bus.in_b = i2f(k);
            bus.in_op = 1'b1; bus.in_tag = 4'(k);
            @(negedge clk);
            if (bus.in_ready) acc++;
            tick();
        end
        chk("bp_accepts", acc, DEPTH);
        repeat (8) tick();
        @(negedge clk);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_count_full", dut.count, DEPTH);
        chk("bp_credits_zero", dut.credits, 0);
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_pop", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_refill", bus.in_ready, 0);
        drain(40);

        // Simultaneous accept and pop with one credit left.
        for (int k = 0; k < 7; k++) begin
            bus.in_valid = 1'b1; bus.in_a = i2f(k + 5); bus.in_b = i2f(3);
            bus.in_op = 1'b0; bus.in_tag = 4'(k + 8);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("sim_credits_before", dut.credits, 1);
        chk("sim_count_before", dut.count, 7);
        tick();
        bus.in_valid = 1'b1; bus.in_a = i2f(42); bus.in_b = i2f(1); bus.in_tag = 4'd15;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("sim_credits_after", dut.credits, 1);
        chk("sim_count_after", dut.count, 6);
        chk("sim_in_ready", bus.in_ready, 1);
        drain(40);

        // Reset with three ops in flight.
        tick();
        bus.in_valid = 1'b1; bus.in_a = i2f(7); bus.in_b = i2f(7); bus.in_tag = 4'd1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_flight_out_valid", bus.out_valid, 0);
            tick();
        end
        bus.out_ready = 1'b0;
        chk("rst_flight_credits", dut.credits, DEPTH);
        chk("rst_flight_busy", bus.busy, 0);

`ifdef FPU_SEQ_STATUS_EN
        tick();
        one_op(32'h7F800000, 32'hFF800000, 1'b0, 4'd6, lat);
        chk("nan_exp", bus.out_r[30:23], 8'hFF);
        chk("nan_frac_nz", bus.out_r[22:0] != 0, 1);
        chk("nan_flags", bus.out_flags, 3'b100);
        pop_one();
        one_op(32'h3F800000, 32'h3F800000, 1'b1, 4'd7, lat);
        chk("zero_out_r", bus.out_r, 32'h00000000);
        chk("zero_flags", bus.out_flags, 3'b001);
        pop_one();
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
